// File: rtl/fm_key_if.sv
// Read-bus bundle between the CPU side and the front-panel key peripheral.
// Carries the read address/strobe, the registered read data and the level interrupt.
interface fm_key_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] rdaddr;
  logic              rden;
  logic [31:0]       rdata;
  logic              irq;

  modport master (output rdaddr, output rden, input rdata, input irq);
  modport slave  (input rdaddr, input rden, output rdata, output irq);
endinterface

// File: rtl/fm_key_input.sv
// Front-panel key peripheral: synchronises and debounces active-low buttons, latches
// sticky press / long-press events and exposes them as a clear-on-read status word plus irq.
module fm_key_input #(
  parameter int                       FM_ADDR_WIDTH   = 13,
  parameter int                       NUM_KEYS        = 4,
  parameter int                       DEBOUNCE_CYCLES = 1000000,
  parameter int                       LONG_CYCLES     = 50000000,
  parameter logic [FM_ADDR_WIDTH-1:0] STATUS_ADDR     = 13'h00C
) (
  input  logic                clk,
  input  logic                RST,
  input  logic [NUM_KEYS-1:0] key_n,
  fm_key_if.slave             bus
);

  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW  = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DCW-1:0] DEB_MAX  = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  LONG_MAX = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} key_st_e;

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] deb_q, deb_d;
  logic [DCW-1:0]      dcnt_q [NUM_KEYS];
  logic [DCW-1:0]      dcnt_d [NUM_KEYS];
  key_st_e             state_q [NUM_KEYS];
  key_st_e             state_d [NUM_KEYS];
  logic [HW-1:0]       hcnt_q [NUM_KEYS];
  logic [HW-1:0]       hcnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] long_q, long_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                irq_q, irq_d;

  logic [NUM_KEYS-1:0] set_press, set_long;
  logic                clr;
  logic                ovf_set;
  logic [31:0]         status;

  always_comb begin
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    set_press = '0;
    set_long  = '0;
    clr       = bus.rden && (bus.rdaddr == STATUS_ADDR);

    for (int i = 0; i < NUM_KEYS; i++) begin
      // Counter runs only while the pressed-level disagrees with the accepted level.
      dcnt_d[i] = '0;
      if ((~sync2_q[i]) != deb_q[i]) begin
        if (dcnt_q[i] == DEB_MAX) deb_d[i] = ~deb_q[i];
        else                      dcnt_d[i] = dcnt_q[i] + 1'b1;
      end

      // FSM follows the next-state debounced level so a press event lands with deb.
      state_d[i] = state_q[i];
      hcnt_d[i]  = hcnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (deb_d[i]) begin
            set_press[i] = 1'b1;
            hcnt_d[i]    = '0;
            state_d[i]   = ST_HELD;
          end
        end
        ST_HELD: begin
          if (!deb_d[i]) begin
            state_d[i] = ST_IDLE;
          end else if (hcnt_q[i] == LONG_MAX) begin
            set_long[i] = 1'b1;
            state_d[i]  = ST_LONG;
          end else if (hcnt_q[i] != '1) begin
            hcnt_d[i] = hcnt_q[i] + 1'b1;
          end
        end
        ST_LONG: begin
          if (!deb_d[i]) state_d[i] = ST_IDLE;
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end

    // A new event coinciding with a clearing read is delivered, not counted as lost.
    ovf_set = (|((set_press & press_q) | (set_long & long_q))) & ~clr;
    press_d = (clr ? '0 : press_q) | set_press;
    long_d  = (clr ? '0 : long_q) | set_long;
    ovf_d   = (clr ? 1'b0 : ovf_q) | ovf_set;

    status  = {ovf_q, 7'b0, 8'(long_q), 8'(deb_q), 8'(press_q)};
    rdata_d = rdata_q;
    if (bus.rden) rdata_d = clr ? status : 32'h0;
    irq_d   = |(press_d | long_d);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '0;
      press_q <= '0;
      long_q  <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= 32'h0;
      irq_q   <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        dcnt_q[i]  <= '0;
        state_q[i] <= ST_IDLE;
        hcnt_q[i]  <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      press_q <= press_d;
      long_q  <= long_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        dcnt_q[i]  <= dcnt_d[i];
        state_q[i] <= state_d[i];
        hcnt_q[i]  <= hcnt_d[i];
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_fm_key_input.sv
// Directed bench for fm_key_input with short debounce/long-press times; every expected
// status word is hand-computed from the register bit map.
module tb_fm_key_input;

  localparam logic [12:0] SADDR = 13'h00C;

  logic       clk = 1'b0;
  logic       RST;
  logic [3:0] key_n;
  int         checks = 0;
  int         errors = 0;

  fm_key_if #(.ADDR_W(13)) bus ();

  fm_key_input #(
    .FM_ADDR_WIDTH  (13),
    .NUM_KEYS       (4),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (16),
    .STATUS_ADDR    (SADDR)
  ) dut (
    .clk  (clk),
    .RST  (RST),
    .key_n(key_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [12:0] addr);
    bus.rdaddr = addr;
    bus.rden   = 1'b1;
    tick();
    bus.rden   = 1'b0;
    bus.rdaddr = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RST        = 1'b1;
    key_n      = 4'hF;
    bus.rden   = 1'b0;
    bus.rdaddr = '0;
    tick(3);
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_irq", {31'b0, bus.irq}, 32'h0);
    RST = 1'b0;
    tick();
    rd(SADDR);
    check("idle_read", bus.rdata, 32'h0);

    // Glitch of 3 cycles must be rejected.
    key_n[0] = 1'b0;
    tick(3);
    key_n[0] = 1'b1;
    tick(8);
    check("glitch_irq", {31'b0, bus.irq}, 32'h0);
    rd(SADDR);
    check("glitch_read", bus.rdata, 32'h0);

    // Real press on key 0.
    key_n[0] = 1'b0;
    tick(5);
    check("pre_debounce_irq", {31'b0, bus.irq}, 32'h0);
    tick(1);
    check("debounce_irq", {31'b0, bus.irq}, 32'h1);
    tick(4);
    key_n[0] = 1'b1;
    rd(SADDR);
    check("press0_read", bus.rdata, 32'h0000_0101);
    check("press0_irq_cleared", {31'b0, bus.irq}, 32'h0);
    rd(SADDR);
    check("press0_reread", bus.rdata, 32'h0000_0100);
    tick(10);

    // Long press on key 2.
    key_n[2] = 1'b0;
    tick(30);
    check("long2_irq", {31'b0, bus.irq}, 32'h1);
    rd(SADDR);
    check("long2_read", bus.rdata, 32'h0004_0404);
    key_n[2] = 1'b1;
    tick(8);
    rd(SADDR);
    check("long2_release_read", bus.rdata, 32'h0);
    check("long2_release_irq", {31'b0, bus.irq}, 32'h0);

    // Two presses of key 1 without a read -> overflow.
    key_n[1] = 1'b0; tick(8);
    key_n[1] = 1'b1; tick(8);
    key_n[1] = 1'b0; tick(8);
    key_n[1] = 1'b1; tick(8);
    rd(SADDR);
    check("ovf_read", bus.rdata, 32'h8000_0002);
    rd(SADDR);
    check("ovf_cleared_read", bus.rdata, 32'h0);
    check("ovf_cleared_irq", {31'b0, bus.irq}, 32'h0);

    // Key 3 press lands on the same edge as a clearing read.
    key_n[1] = 1'b0; tick(8);
    key_n[1] = 1'b1; tick(8);
    key_n[3] = 1'b0;
    tick(5);
    rd(SADDR);
    check("collide_read", bus.rdata, 32'h0000_0002);
    check("collide_irq", {31'b0, bus.irq}, 32'h1);
    rd(SADDR);
    check("collide_next_read", bus.rdata, 32'h0000_0808);
    key_n[3] = 1'b1;
    tick(8);
    rd(SADDR);
    check("collide_final_read", bus.rdata, 32'h0);
    check("collide_final_irq", {31'b0, bus.irq}, 32'h0);

    // Reset while keys are held.
    key_n[1] = 1'b0;
    tick(7);
    rd(SADDR);
    check("pre_reset_read", bus.rdata, 32'h0000_0202);
    key_n[0] = 1'b0;
    tick(7);
    check("pre_reset_irq", {31'b0, bus.irq}, 32'h1);
    check("rdata_hold", bus.rdata, 32'h0000_0202);
    RST = 1'b1;
    tick();
    check("midreset_rdata", bus.rdata, 32'h0);
    check("midreset_irq", {31'b0, bus.irq}, 32'h0);
    RST = 1'b0;
    tick(5);
    check("post_reset_early_irq", {31'b0, bus.irq}, 32'h0);
    tick(1);
    check("post_reset_press_irq", {31'b0, bus.irq}, 32'h1);
    rd(SADDR);
    check("post_reset_read", bus.rdata, 32'h0000_0303);
    key_n = 4'hF;
    tick(8);
    check("post_reset_hold", bus.rdata, 32'h0000_0303);
    rd(SADDR);
    check("post_reset_release_read", bus.rdata, 32'h0);

    // Read at another address must return 0 and keep the event.
    key_n[2] = 1'b0; tick(8);
    key_n[2] = 1'b1; tick(8);
    rd(SADDR + 13'd4);
    check("other_addr_read", bus.rdata, 32'h0);
    check("other_addr_irq", {31'b0, bus.irq}, 32'h1);
    rd(SADDR);
    check("retained_read", bus.rdata, 32'h0000_0004);
    check("retained_irq", {31'b0, bus.irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
